noc_injection_arbiter: RTL

- Shares one router injection channel between NUM_REQ local traffic sources using round-robin arbitration with credit-based flow control.
- Packs each granted word into a registered flit: 4-bit destination, noc_dw payload, valid.
- Sits between traffic generators / processors and a router_wrap channel_in slot; credits return from the router's flow_ctrl_out.

---
 rtl/noc_injection_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/noc_injection_arbiter.sv
// Round-robin injection arbiter with credit flow control for one router channel.
// Optional per-requester grant / stall statistics when INJ_ARB_STATS_EN is defined.
module noc_injection_arbiter #(
    parameter int noc_dw  = 32,
    parameter int NUM_REQ = 4,
    parameter int CREDITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                router_address,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*noc_dw-1:0] req_data,
    input  logic [NUM_REQ*4-1:0]      req_dest,
    output logic                      flit_valid,
    output logic [3:0]                flit_dest,
    output logic [noc_dw-1:0]         flit_data,
    input  logic                      credit_return,
    output logic [3:0]                credit_cnt,
    output logic                      err_self,
`ifdef INJ_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]     grant_count,
    output logic [15:0]               stall_cycles,
`endif
    output logic                      err_credit
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    typedef enum logic [1:0] {IDLE, ARB, STALL} state_e;

    state_e            state;
    logic [PW-1:0]     rr_q, rr_d;
    logic [PW-1:0]     gnt_idx;
    logic              found;
    logic              accept;
    logic              self_hit;
    logic [3:0]        sel_dest;
    logic [noc_dw-1:0] sel_data;

    logic              flit_valid_q, flit_valid_d;
    logic [3:0]        flit_dest_q, flit_dest_d;
    logic [noc_dw-1:0] flit_data_q, flit_data_d;
    logic [3:0]        credit_q, credit_d;
    logic              err_self_q, err_self_d;
    logic              err_credit_q, err_credit_d;

    // State is decoded each cycle from the registered credit count and live requests
    always_comb begin
        state = IDLE;
        if (credit_q == 4'd0)
            state = STALL;
        else if (|req_valid)
            state = ARB;
    end

    always_comb begin
        int idx;
        idx       = 0;
        found     = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
        if (state == ARB && found && !reset)
            req_ready[gnt_idx] = 1'b1;
    end

    assign accept   = |req_ready;
    assign sel_dest = req_dest[int'(gnt_idx)*4 +: 4];
    assign sel_data = req_data[int'(gnt_idx)*noc_dw +: noc_dw];
    assign self_hit = (sel_dest == router_address);

    always_comb begin
        rr_d         = rr_q;
        flit_valid_d = 1'b0;
        flit_dest_d  = flit_dest_q;
        flit_data_d  = flit_data_q;
        err_self_d   = 1'b0;
        credit_d     = credit_q;
        err_credit_d = err_credit_q;
        if (accept) begin
            rr_d = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (self_hit) begin
                err_self_d = 1'b1;
            end else begin
                flit_valid_d = 1'b1;
                flit_dest_d  = sel_dest;
                flit_data_d  = sel_data;
            end
        end
        if (flit_valid_d && !credit_return) begin
            credit_d = credit_q - 4'd1;
        end else if (!flit_valid_d && credit_return) begin
            if (credit_q == CRED_MAX)
                err_credit_d = 1'b1;
            else
                credit_d = credit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q         <= '0;
            flit_valid_q <= 1'b0;
            flit_dest_q  <= '0;
            flit_data_q  <= '0;
            credit_q     <= CRED_MAX;
            err_self_q   <= 1'b0;
            err_credit_q <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            flit_valid_q <= flit_valid_d;
            flit_dest_q  <= flit_dest_d;
            flit_data_q  <= flit_data_d;
            credit_q     <= credit_d;
            err_self_q   <= err_self_d;
            err_credit_q <= err_credit_d;
        end
    end

    assign flit_valid = flit_valid_q;
    assign flit_dest  = flit_dest_q;
    assign flit_data  = flit_data_q;
    assign credit_cnt = credit_q;
    assign err_self   = err_self_q;
    assign err_credit = err_credit_q;

`ifdef INJ_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] gcnt_q;
    logic [15:0]              stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            if (accept)
                gcnt_q[gnt_idx] <= gcnt_q[gnt_idx] + 16'd1;
            if (state == STALL && |req_valid && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign grant_count  = gcnt_q;
    assign stall_cycles = stall_q;
`endif

endmodule
